// File: rtl/serial_adder_ctrl_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and the
// default operand width.
package serial_arith_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Width of the bit counter for a given operand width; one extra bit so the
  // counter can represent WIDTH itself.
  function automatic int cnt_width(input int width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/serial_adder_ctrl_if.sv
// Request/result bundle of the bit-serial adder. The requester drives start
// and the operands; the adder returns busy/done and the registered result.
interface serial_adder_ctrl_if
  import serial_arith_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (
    output start, a, b, cin,
    input  busy, done, sum, cout
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, cout
  );

  modport mon (
    input start, a, b, cin, busy, done, sum, cout
  );

endinterface

// File: rtl/serial_adder_ctrl_chk.sv
// Protocol checker for the bit-serial adder result interface.
module serial_adder_ctrl_chk (
  input logic          clk,
  input logic          rst,
  serial_adder_ctrl_if.mon bus
);

  property p_done_pulse;
    @(posedge clk) disable iff (rst) bus.done |=> !bus.done;
  endproperty

  property p_done_busy;
    @(posedge clk) disable iff (rst) bus.done |-> bus.busy;
  endproperty

  property p_known;
    @(posedge clk) disable iff (rst)
      !$isunknown({bus.busy, bus.done, bus.cout, bus.sum});
  endproperty

  a_done_pulse: assert property (p_done_pulse);
  a_done_busy:  assert property (p_done_busy);
  a_known:      assert property (p_known);

endmodule

// File: rtl/serial_adder_ctrl_fadder.sv
// Existing decoder-based full adder: the three inputs are decoded to a
// one-hot minterm vector and sum/carry are ORs of the relevant minterms.
module fadder (
  input  logic x,
  input  logic y,
  input  logic z,
  output logic sum,
  output logic carry
);

  logic [2:0] idx_s;
  logic [7:0] dec_s;

  assign idx_s = {x, y, z};

  // 3-to-8 minterm decoder
  always_comb begin
    dec_s        = 8'd0;
    dec_s[idx_s] = 1'b1;
  end

  // Sum is odd parity (minterms 1,2,4,7); carry is majority (3,5,6,7)
  always_comb begin
    sum   = dec_s[1] | dec_s[2] | dec_s[4] | dec_s[7];
    carry = dec_s[3] | dec_s[5] | dec_s[6] | dec_s[7];
  end

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller. Operands are shifted LSB first through a
// single full-adder cell with the carry looped back through a flip-flop;
// the result is published after WIDTH clocks and held until the next one.
module serial_adder_ctrl
  import serial_arith_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic clk,
  input  logic rst,
  serial_adder_ctrl_if.slave bus
);

  localparam int               CNT_W    = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_e           state_r;
  state_e           state_next_s;
  logic [WIDTH-1:0] a_sh_r;
  logic [WIDTH-1:0] b_sh_r;
  logic [WIDTH-1:0] s_sh_r;
  logic [WIDTH-1:0] s_next_s;
  logic [WIDTH-1:0] sum_r;
  logic             carry_r;
  logic             cout_r;
  logic [CNT_W-1:0] cnt_r;
  logic             fa_sum_s;
  logic             fa_carry_s;
  logic             load_s;
  logic             step_s;
  logic             last_s;

  // The only arithmetic element: one bit pair plus looped-back carry per clock
  fadder u_fadder (
    .x     (a_sh_r[0]),
    .y     (b_sh_r[0]),
    .z     (carry_r),
    .sum   (fa_sum_s),
    .carry (fa_carry_s)
  );

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic and datapath strobes; start only matters in IDLE
  always_comb begin
    state_next_s = state_r;
    load_s       = 1'b0;
    step_s       = 1'b0;
    last_s       = (cnt_r == CNT_LAST);
    case (state_r)
      ST_IDLE: begin
        if (bus.start) begin
          load_s       = 1'b1;
          state_next_s = ST_RUN;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        step_s = 1'b1;
        if (last_s) begin
          state_next_s = ST_DONE;
        end else begin
          state_next_s = ST_RUN;
        end
      end
      ST_DONE: begin
        state_next_s = ST_IDLE;
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // New sum bit enters at the MSB so the LSB-first bits land in place
  always_comb begin
    s_next_s           = s_sh_r >> 1;
    s_next_s[WIDTH-1]  = fa_sum_s;
  end

  // Operand/sum shift registers, carry flip-flop, bit counter and result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh_r  <= {WIDTH{1'b0}};
      b_sh_r  <= {WIDTH{1'b0}};
      s_sh_r  <= {WIDTH{1'b0}};
      carry_r <= 1'b0;
      cnt_r   <= {CNT_W{1'b0}};
      sum_r   <= {WIDTH{1'b0}};
      cout_r  <= 1'b0;
    end else if (load_s) begin
      a_sh_r  <= bus.a;
      b_sh_r  <= bus.b;
      s_sh_r  <= {WIDTH{1'b0}};
      carry_r <= bus.cin;
      cnt_r   <= {CNT_W{1'b0}};
    end else if (step_s) begin
      a_sh_r  <= a_sh_r >> 1;
      b_sh_r  <= b_sh_r >> 1;
      s_sh_r  <= s_next_s;
      carry_r <= fa_carry_s;
      cnt_r   <= cnt_r + CNT_ONE;
      if (last_s) begin
        sum_r  <= s_next_s;
        cout_r <= fa_carry_s;
      end
    end
  end

  assign bus.busy = (state_r != ST_IDLE);
  assign bus.done = (state_r == ST_DONE);
  assign bus.sum  = sum_r;
  assign bus.cout = cout_r;

endmodule

// File: doc/serial_adder_ctrl.md
Name: serial_adder_ctrl

Overview:
- Bit-serial adder built around the team's existing decoder-based full adder (`fadder`). It sits directly upstream of that cell and feeds it one bit pair per clock, LSB first, with the carry looped back through a flip-flop.
- It accepts two WIDTH-bit operands plus a carry-in on a start pulse and produces a WIDTH-bit sum and a carry-out after WIDTH clocks.
- The trade is area for latency: a single full-adder cell serves any operand width.

Parameters:
- WIDTH, 8, operand/sum width in bits; legal range 1..32.
- CNT_W, $clog2(WIDTH)+1, bit-counter width; derived locally, not overridden.

Ports:
- clk  input  1  single system clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-high.
- start  input  1  request; sampled only in IDLE.
- a  input  WIDTH  operand A; captured on accepted start.
- b  input  WIDTH  operand B; captured on accepted start.
- cin  input  1  carry-in; captured on accepted start.
- busy  output  1  high in RUN and DONE.
- done  output  1  one-cycle pulse; result valid.
- sum  output  WIDTH  result; holds its value until the next completion.
- cout  output  1  final carry; holds its value until the next completion.

Behaviour:
- Reset (async, rst=1):
  - State goes to IDLE.
  - busy=0, done=0, sum=0, cout=0.
  - Shift registers, carry flip-flop and counter are all cleared.
- Reset mid-operation aborts with no done pulse and no partial result on sum/cout.
- FSM states are IDLE, RUN, DONE.
- IDLE:
  - start=1 at edge E0 loads a_sh<=a, b_sh<=b, carry<=cin, cnt<=0, and moves to RUN.
  - start=0 stays in IDLE.
- RUN, on each edge:
  - The fadder sees x=a_sh[0], y=b_sh[0], z=carry.
  - s_sh<={fadder.sum, s_sh[WIDTH-1:1]}.
  - a_sh and b_sh shift right by 1.
  - carry<=fadder.carry.
  - cnt<=cnt+1.
  - When cnt==WIDTH-1 on this edge, also load sum<={fadder.sum, s_sh[WIDTH-1:1]} and cout<=fadder.carry, and go to DONE.
- DONE:
  - done=1 for exactly this one cycle.
  - The next edge returns to IDLE unconditionally.
- Latency:
  - Start is accepted at E0.
  - sum/cout update at edge E_WIDTH.
  - done is high during the cycle following E_WIDTH.
  - Next start is accepted no earlier than edge E_(WIDTH+2).
  - Throughput is one add per WIDTH+2 clocks.
- Start rules:
  - start in RUN or DONE is ignored; it is not queued.
  - a/b/cin may change freely after acceptance.
- Arithmetic: {cout,sum} = a + b + cin, modulo 2^(WIDTH+1); unsigned, exact, no overflow flag.
- WIDTH=1: RUN lasts exactly one cycle.
- done and busy are decoded directly from the state register, so they are glitch-free registered values.
- No X on any output after reset deassertion.

Decomposition:
- Shared package serial_arith_pkg:
  - State encoding constants ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2.
  - Default WIDTH constant.
- Sub-module: the existing fadder, instantiated once as the sole arithmetic element. No other adder logic is permitted in this block.
- The FSM, counter and shift registers stay in serial_adder_ctrl; no further split is needed at this size.

Test Plan:
- Basic add, WIDTH=8: a=8'h5A, b=8'h3C, cin=0, start at E0.
  - Required: sum=8'h96, cout=0, done high exactly one cycle after E8, busy high E1..E9.
- Carry ripple and carry-in cases, WIDTH=8:
  - a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1.
  - a=8'hFF, b=8'hFF, cin=1 -> sum=8'hFF, cout=1.
  - a=0, b=0, cin=1 -> sum=8'h01, cout=0.
- Start while busy: a=8'h10, b=8'h20 at E0; at E3 drive start=1 with a=8'hAA.
  - Required: result 8'h30, single done pulse, second request dropped.
  - A start asserted at E_WIDTH+2 is then accepted normally.
- Reset mid-operation: start a=8'h7F, b=8'h01; assert rst asynchronously between E4 and E5.
  - Required: immediate busy=0, sum=0, cout=0, no done.
  - After release, a fresh add of 8'h03+8'h04 gives 8'h07.
- Exhaustive sweep, WIDTH=4: all 512 (a,b,cin) combinations back-to-back at maximum rate.
  - Required: every result matches a+b+cin, and there is exactly one done per start.
- Minimal width, WIDTH=1: all 8 input combinations.
  - Required: {cout,sum} equals the full-adder truth table, and done arrives one cycle after E1.
